// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that steers one of N_REQ requesters into a single-entry
// output register with a valid/ready handshake toward one consumer.
module mux_rr_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  localparam int SRC_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_vld,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_rdy,
  output logic                   out_vld,
  output logic [WIDTH-1:0]       out_data,
  output logic [SRC_W-1:0]       out_src,
  input  logic                   out_rdy
);

  logic [N_REQ-1:0][WIDTH-1:0] lanes;
  logic [SRC_W-1:0]            ptr;
  logic [SRC_W-1:0]            gnt_idx;
  logic                        gnt_any;
  logic [N_REQ-1:0]            gnt_oh;
  logic                        load_en;
  logic [SRC_W-1:0]            ptr_nxt;

  assign lanes   = req_data;
  assign load_en = !out_vld || out_rdy;

  // Scan starting at ptr, wrapping past N_REQ-1; first valid requester wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!gnt_any && req_vld[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = SRC_W'(idx);
      end
    end
  end

  genvar i;
  generate
    for (i = 0; i < N_REQ; i++) begin : g_oh
      assign gnt_oh[i] = gnt_any && (gnt_idx == SRC_W'(i));
    end
  endgenerate

  // Reset suppresses handshakes so no requester believes it was accepted.
  assign req_rdy = (rst || !load_en) ? '0 : gnt_oh;

  assign ptr_nxt = (gnt_idx == SRC_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_src  <= '0;
      ptr      <= '0;
    end else if (load_en) begin
      out_vld <= gnt_any;
      if (gnt_any) begin
        out_data <= lanes[gnt_idx];
        out_src  <= gnt_idx;
        ptr      <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: reset, rotation, wrap, backpressure,
// idle and mid-transfer reset, with hand-computed expectations.
module tb_mux_rr_arbiter;
  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int SRC_W = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req_vld;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_rdy;
  logic                   out_vld;
  logic [WIDTH-1:0]       out_data;
  logic [SRC_W-1:0]       out_src;
  logic                   out_rdy;

  int checks   = 0;
  int failures = 0;

  mux_rr_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data),
    .req_rdy(req_rdy), .out_vld(out_vld), .out_data(out_data),
    .out_src(out_src), .out_rdy(out_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
    chk({tag, ".vld"}, 32'(out_vld), 32'(v));
    chk({tag, ".data"}, 32'(out_data), 32'(d));
    chk({tag, ".src"}, 32'(out_src), 32'(s));
  endtask

  initial begin
    rst      = 1'b1;
    req_vld  = 4'b1111;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    out_rdy  = 1'b1;
    tick();
    tick();
    chk_out("reset", 1'b0, 8'h00, 2'd0);
    chk("reset.rdy", 32'(req_rdy), 32'h0);

    rst      = 1'b0;
    req_vld  = 4'b0001;
    req_data = {8'h13, 8'h12, 8'h11, 8'hA5};
    #1;
    chk("first.rdy", 32'(req_rdy), 32'b0001);
    tick();
    chk_out("first", 1'b1, 8'hA5, 2'd0);

    // grant 3 to bring ptr back to 0
    req_vld  = 4'b1000;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    tick();
    chk_out("pre3", 1'b1, 8'h13, 2'd3);

    req_vld = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_out($sformatf("rot%0d", k), 1'b1, 8'(8'h10 + (k % 4)), 2'(k % 4));
    end

    req_vld = 4'b0100;
    tick();
    chk_out("wrap.g2", 1'b1, 8'h12, 2'd2);
    req_vld = 4'b0101;
    tick();
    chk_out("wrap.g0a", 1'b1, 8'h10, 2'd0);
    tick();
    chk_out("wrap.g2b", 1'b1, 8'h12, 2'd2);
    tick();
    chk_out("wrap.g0c", 1'b1, 8'h10, 2'd0);

    // ptr is now 1; hold the register full
    out_rdy = 1'b0;
    req_vld = 4'b1111;
    #1;
    chk("bp.rdy0", 32'(req_rdy), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out($sformatf("bp%0d", k), 1'b1, 8'h10, 2'd0);
      chk($sformatf("bp%0d.rdy", k), 32'(req_rdy), 32'h0);
    end
    out_rdy = 1'b1;
    #1;
    chk("bp.resume.rdy", 32'(req_rdy), 32'b0010);
    tick();
    chk_out("bp.resume", 1'b1, 8'h11, 2'd1);

    // ptr is now 2; idle cycles must not move it
    req_vld = 4'b0000;
    #1;
    chk("idle.rdy", 32'(req_rdy), 32'h0);
    tick();
    chk_out("idle0", 1'b0, 8'h11, 2'd1);
    tick();
    chk_out("idle1", 1'b0, 8'h11, 2'd1);
    req_vld = 4'b1111;
    #1;
    chk("idle.ptr", 32'(req_rdy), 32'b0100);
    req_vld = 4'b0010;
    #1;
    chk("single1.rdy", 32'(req_rdy), 32'b0010);
    tick();
    chk_out("single1", 1'b1, 8'h11, 2'd1);

    // mid-transfer reset drops held data and rewinds ptr
    out_rdy = 1'b0;
    req_vld = 4'b1111;
    tick();
    chk_out("hold", 1'b1, 8'h11, 2'd1);
    rst = 1'b1;
    tick();
    chk_out("midrst", 1'b0, 8'h00, 2'd0);
    rst     = 1'b0;
    out_rdy = 1'b1;
    #1;
    chk("postrst.rdy", 32'(req_rdy), 32'b0001);
    tick();
    chk_out("postrst", 1'b1, 8'h10, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
